dc_store_ctrl: RTL and testbench
================================

Name: dc_store_ctrl

Overview:
Data-cache store port that sits directly downstream of the store buffer. It accepts one drained store (word or byte) at a time and holds a small direct-mapped, write-allocate, write-back line array. On a hit it merges the store into the line. On a miss it writes back a dirty victim if needed, fills the line from memory, then merges. A combinational read port lets the load path probe the array.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, store/load data width
LINES, 4, number of lines (power of 2)
LINE_BYTES, 16, bytes per line (power of 2, >= 4)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
st_valid  input  1  store buffer presents a store (dc_store)
st_ready  output  1  store accepted this cycle when st_valid && st_ready
st_addr  input  ADDR_W  store byte address
st_data  input  DATA_W  store data; byte stores use bits [7:0]
st_is_byte  input  1  1 = byte store, 0 = word store
st_done  output  1  one-cycle pulse when a store is committed to the array
rd_addr  input  ADDR_W  load probe address
rd_data  output  DATA_W  aligned word at rd_addr when rd_hit, else 0
rd_hit  output  1  valid line with matching tag
mem_req  output  1  memory request
mem_we  output  1  1 = line write-back, 0 = line fill
mem_addr  output  ADDR_W  line-aligned memory address
mem_wdata  output  LINE_BYTES*8  victim line data
mem_ack  input  1  memory completes request; mem_rdata valid this cycle
mem_rdata  input  LINE_BYTES*8  fill line data

Behaviour:
- Address split: offset = low log2(LINE_BYTES) bits, index = next log2(LINES) bits, tag = the rest. Lines are little-endian: byte k of a line is at bits [8k+7:8k].
- Word stores ignore addr[1:0] (aligned down). Byte stores write only byte offset addr[off].
- Reset (reset=0, async): state IDLE, all valid and dirty bits 0, request registers 0. Outputs: st_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. st_ready=1 once IDLE is reached. Line data contents are not reset.
- States: IDLE, CHECK, WB, FILL. st_ready = (state==IDLE).
- IDLE: on st_valid, latch addr/data/is_byte and go to CHECK.
- CHECK, hit: merge the store into the line, set dirty=1, pulse st_done, return to IDLE. Hit latency is 2 cycles from acceptance to st_done.
- CHECK, miss with victim valid && dirty: register mem_req=1, mem_we=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line; go to WB.
- CHECK, miss otherwise: register mem_req=1, mem_we=0, mem_addr = {req tag, index, 0}; go to FILL.
- WB: hold all mem_* stable until mem_ack. On ack, clear dirty, switch to the fill request (mem_we=0, new address), go to FILL. mem_req stays high.
- FILL: hold until mem_ack. On ack: line = mem_rdata with the store merged over it, tag written, valid=1, dirty=1, mem_req=0, st_done pulse, go to IDLE.
- mem_ack outside WB/FILL is ignored. mem_req never drops before ack except on reset.
- Read port is purely combinational on the current array contents. A read in the same cycle as a commit returns the pre-commit contents.
- Reset mid-miss drops mem_req asynchronously. The pending store is lost; the store buffer re-drives it.
- st_valid while not IDLE is ignored (not accepted).

Test Plan:
- Reset, then store word 0x000000A0 <= 0xDEADBEEF, mem_ack returns an all-zero line → FILL with mem_addr=0x000000A0, mem_we=0; st_done after ack; rd_addr 0xA0 gives rd_hit=1, rd_data=0xDEADBEEF.
- Byte store 0xA1 <= 0x55 on the now-resident line → no mem_req, st_done 2 cycles after acceptance; rd 0xA0 = 0xDEAD55EF.
- Store word 0x000001A0 <= 0x1 (same index, different tag, line dirty) → WB first with mem_we=1, mem_addr=0xA0, mem_wdata[31:0]=0xDEAD55EF; then FILL with mem_addr=0x1A0; rd 0x1A0 = 0x1 and rd 0xA0 misses.
- Hold mem_ack low for 10 cycles in FILL → mem_req, mem_addr and mem_we stay stable; st_ready=0; a second st_valid is not accepted.
- Assert reset low mid-FILL → mem_req=0 immediately; after release st_ready=1, rd_hit=0 for all addresses.
- Back-to-back hits on 4 stores to 0xA0..0xAC → one st_done every 2 cycles, rd_data matches each word.

Source files
------------

// File: rtl/dc_store_ctrl.sv
// Data-cache store port: direct-mapped, write-allocate, write-back line array
// fed by the store buffer, with a combinational load probe.
module dc_store_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [ADDR_W-1:0]       st_addr,
  input  logic [DATA_W-1:0]       st_data,
  input  logic                    st_is_byte,
  output logic                    st_done,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_ack,
  input  logic [LINE_BYTES*8-1:0] mem_rdata
);
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int IDX_W      = $clog2(LINES);
  localparam int TAG_W      = ADDR_W - OFF_W - IDX_W;
  localparam int LINE_W     = LINE_BYTES * 8;
  localparam int WORD_BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

  // Field order matches the address bit order so st_addr packs straight in.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] data;
    logic              is_byte;
  } req_t;

  state_t             state;
  req_t               req;
  logic [LINE_W-1:0]  line_q [LINES];
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [LINES-1:0]   valid_q, dirty_q;

  function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line,
                                              input logic [OFF_W-1:0]  off,
                                              input logic [DATA_W-1:0] d,
                                              input logic              is_byte);
    logic [LINE_W-1:0] r;
    int                base;
    r    = line;
    base = int'(off) & ~(WORD_BYTES - 1);
    if (is_byte) r[int'(off)*8 +: 8] = d[7:0];
    else         r[base*8 +: DATA_W] = d;
    return r;
  endfunction

  // Load probe: reads the registered array, so a same-cycle commit is not visible.
  logic [TAG_W-1:0]  rd_tag;
  logic [IDX_W-1:0]  rd_idx;
  logic [OFF_W-1:0]  rd_off;
  logic [LINE_W-1:0] rd_line;
  assign {rd_tag, rd_idx, rd_off} = rd_addr;

  always_comb begin
    rd_line = line_q[rd_idx];
    rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_data = '0;
    if (rd_hit) rd_data = rd_line[(int'(rd_off) & ~(WORD_BYTES - 1))*8 +: DATA_W];
  end

  logic [LINE_W-1:0] cur_line, commit_line;
  logic              hit, commit;
  assign cur_line = line_q[req.idx];
  assign hit      = valid_q[req.idx] && (tag_q[req.idx] == req.tag);
  assign st_ready = (state == IDLE);

  always_comb begin
    commit      = 1'b0;
    commit_line = merge(cur_line, req.off, req.data, req.is_byte);
    if (state == CHECK && hit) commit = 1'b1;
    if (state == FILL && mem_ack) begin
      commit      = 1'b1;
      commit_line = merge(mem_rdata, req.off, req.data, req.is_byte);
    end
  end

  // Line data and tags are not reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (commit) begin
      line_q[req.idx] <= commit_line;
      tag_q[req.idx]  <= req.tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req       <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      st_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      st_done <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid) begin
            req   <= {st_addr, st_data, st_is_byte};
            state <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            dirty_q[req.idx] <= 1'b1;
            st_done          <= 1'b1;
            state            <= IDLE;
          end else if (valid_q[req.idx] && dirty_q[req.idx]) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tag_q[req.idx], req.idx, {OFF_W{1'b0}}};
            mem_wdata <= cur_line;
            state     <= WB;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {req.tag, req.idx, {OFF_W{1'b0}}};
            state    <= FILL;
          end
        end
        WB: begin
          // mem_req stays high: the fill request follows the write-back directly.
          if (mem_ack) begin
            dirty_q[req.idx] <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= {req.tag, req.idx, {OFF_W{1'b0}}};
            state            <= FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid_q[req.idx] <= 1'b1;
            dirty_q[req.idx] <= 1'b1;
            mem_req          <= 1'b0;
            st_done          <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dc_store_ctrl.sv
// Bench for dc_store_ctrl: table of stores with expected memory traffic and read-back
// words, a memory responder, and a done-driven scoreboard of expected read data.
module tb_dc_store_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic         st_valid, st_ready, st_is_byte, st_done;
  logic [31:0]  st_addr, st_data, rd_addr, rd_data, mem_addr;
  logic         rd_hit, mem_req, mem_we, mem_ack;
  logic [127:0] mem_wdata, mem_rdata;

  dc_store_ctrl dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .st_is_byte(st_is_byte), .st_done(st_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_hit(rd_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, data;
    logic        is_byte;
    int          kind;       // number of memory requests: 0 hit, 1 fill, 2 write-back + fill
    logic [31:0] wb_addr, wb_w0, fill_addr, rd_addr, rd_word;
    logic        miss_en;
    logic [31:0] miss_addr;
  } vec_t;
  typedef struct { logic [31:0] addr, word; } exp_t;
  typedef struct { logic we; logic [31:0] addr, w0; } mreq_t;

  int    n_chk = 0, n_fail = 0;
  int    cyc = 0, done_cnt = 0, last_done_cyc = 0;
  int    ack_delay = 2, hold_cnt = 0;
  exp_t  exp_q[$];
  mreq_t req_log[$];
  int    done_cyc_q[$];
  mreq_t cur_req;
  logic [127:0] bk [logic [31:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: logs each request, checks it is held stable, acks after ack_delay.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack  = 1'b0;
      hold_cnt = 0;
    end else if (reset && mem_req) begin
      if (hold_cnt == 0) begin
        cur_req = '{mem_we, mem_addr, mem_wdata[31:0]};
        req_log.push_back(cur_req);
      end else begin
        chk("hold_we", mem_we, cur_req.we);
        chk("hold_addr", mem_addr, cur_req.addr);
      end
      if (hold_cnt >= ack_delay) begin
        if (mem_we) bk[mem_addr] = mem_wdata;
        else mem_rdata = bk.exists(mem_addr) ? bk[mem_addr] : '0;
        mem_ack = 1'b1;
      end
      hold_cnt++;
    end else hold_cnt = 0;
  end

  // Scoreboard: each st_done retires the oldest expected word and probes it.
  always @(negedge clk) begin
    if (st_done) begin
      exp_t e;
      done_cnt++;
      last_done_cyc = cyc;
      done_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        rd_addr = e.addr;
        #1;
        chk("done_rd_hit", rd_hit, 1);
        chk("done_rd_data", rd_data, e.word);
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic b,
                          output int acc);
    int t = 0;
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_is_byte = b;
    while (!st_ready && t < 100) begin @(negedge clk); t++; end
    if (!st_ready) chk("accept_timeout", 0, 1);
    acc = cyc;
    @(posedge clk);
    #1 st_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 300) begin @(negedge clk); t++; end
    if (done_cnt < target) chk("done_timeout", done_cnt, target);
    #2;
  endtask

  function automatic vec_t mk(input logic [31:0] a, d, input logic b, input int k,
                              input logic [31:0] wa, ww, fa, ra, rw,
                              input logic me, input logic [31:0] ma);
    vec_t v;
    v = '{a, d, b, k, wa, ww, fa, ra, rw, me, ma};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   acc, base;
    logic [31:0] miss_list[5];

    tbl[0] = mk(32'hA0,  32'hDEADBEEF, 0, 1, 0,      0,          32'hA0,  32'hA0, 32'hDEADBEEF, 0, 0);
    tbl[1] = mk(32'hA1,  32'h00000055, 1, 0, 0,      0,          0,       32'hA0, 32'hDEAD55EF, 0, 0);
    tbl[2] = mk(32'h1A0, 32'h00000001, 0, 2, 32'hA0, 32'hDEAD55EF, 32'h1A0, 32'h1A0, 32'h1,     1, 32'hA0);
    tbl[3] = mk(32'hA6,  32'h11111111, 0, 2, 32'h1A0, 32'h1,     32'hA0,  32'hA4, 32'h11111111, 1, 32'h1A0);
    tbl[4] = mk(32'hA3,  32'h00000077, 1, 0, 0,      0,          0,       32'hA0, 32'h77AD55EF, 0, 0);
    tbl[5] = mk(32'h13,  32'hCAFEF00D, 0, 1, 0,      0,          32'h10,  32'h10, 32'hCAFEF00D, 0, 0);
    tbl[6] = mk(32'h1F,  32'h123456AB, 1, 0, 0,      0,          0,       32'h1C, 32'hAB000000, 0, 0);
    tbl[7] = mk(32'h5C,  32'h0BADF00D, 0, 2, 32'h10, 32'hCAFEF00D, 32'h50, 32'h5C, 32'h0BADF00D, 1, 32'h10);

    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_is_byte = 1'b0;
    rd_addr = 32'hA0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", st_ready, 1);
    chk("rst_done", st_done, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", |mem_wdata, 0);
    chk("rst_rd_hit", rd_hit, 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req_log.delete();
      base = done_cnt;
      exp_q.push_back('{tbl[i].rd_addr, tbl[i].rd_word});
      do_store(tbl[i].addr, tbl[i].data, tbl[i].is_byte, acc);
      wait_done(base + 1);
      if (tbl[i].kind == 0) chk("hit_latency", 64'(last_done_cyc - acc), 2);
      chk("mem_req_count", req_log.size(), tbl[i].kind);
      if (tbl[i].kind == 1 && req_log.size() >= 1) begin
        chk("fill_we", req_log[0].we, 0);
        chk("fill_addr", req_log[0].addr, tbl[i].fill_addr);
      end
      if (tbl[i].kind == 2 && req_log.size() >= 2) begin
        chk("wb_we", req_log[0].we, 1);
        chk("wb_addr", req_log[0].addr, tbl[i].wb_addr);
        chk("wb_data_w0", req_log[0].w0, tbl[i].wb_w0);
        chk("wb_fill_we", req_log[1].we, 0);
        chk("wb_fill_addr", req_log[1].addr, tbl[i].fill_addr);
      end
      if (tbl[i].miss_en) begin
        rd_addr = tbl[i].miss_addr;
        #1 chk("victim_rd_miss", rd_hit, 0);
      end
    end

    // Back-to-back word hits across line 0xA0; st_valid stays high throughout.
    req_log.delete();
    done_cyc_q.delete();
    base = done_cnt;
    for (int i = 0; i < 4; i++) begin
      int t = 0;
      @(negedge clk);
      while (!st_ready && t < 20) begin @(negedge clk); t++; end
      if (!st_ready) chk("b2b_accept_timeout", 0, 1);
      st_valid = 1'b1; st_addr = 32'hA0 + 32'(4 * i); st_data = 32'h10000000 + 32'(i);
      st_is_byte = 1'b0;
      exp_q.push_back('{32'hA0 + 32'(4 * i), 32'h10000000 + 32'(i)});
      @(posedge clk);
    end
    #1 st_valid = 1'b0;
    wait_done(base + 4);
    chk("b2b_mem_reqs", req_log.size(), 0);
    for (int i = 1; i < 4; i++)
      if (done_cyc_q.size() > i) chk("b2b_spacing", 64'(done_cyc_q[i] - done_cyc_q[i-1]), 2);

    // Slow fill: request held stable, a second store is refused while busy.
    ack_delay = 10;
    req_log.delete();
    base = done_cnt;
    exp_q.push_back('{32'h200, 32'hFEEDFACE});
    do_store(32'h200, 32'hFEEDFACE, 0, acc);
    repeat (2) @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h300; st_data = 32'h0BAD0BAD; st_is_byte = 1'b0;
    repeat (4) begin
      chk("busy_ready", st_ready, 0);
      @(negedge clk);
    end
    chk("slow_mem_req", mem_req, 1);
    chk("slow_mem_we", mem_we, 0);
    chk("slow_mem_addr", mem_addr, 32'h200);
    st_valid = 1'b0;
    wait_done(base + 1);
    repeat (4) @(negedge clk);
    chk("slow_done_count", done_cnt, base + 1);
    rd_addr = 32'h300;
    #1 chk("refused_store_absent", rd_hit, 0);

    // Reset in the middle of a fill.
    ack_delay = 50;
    exp_q.push_back('{32'h30, 32'h5A5A5A5A});
    do_store(32'h30, 32'h5A5A5A5A, 0, acc);
    repeat (4) @(negedge clk);
    chk("midfill_mem_req", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("async_rst_mem_req", mem_req, 0);
    chk("async_rst_ready", st_ready, 1);
    chk("async_rst_mem_addr", mem_addr, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b1;
    ack_delay = 0;
    miss_list = '{32'hA0, 32'h10, 32'h50, 32'h200, 32'h30};
    foreach (miss_list[k]) begin
      rd_addr = miss_list[k];
      #1 chk("post_rst_rd_hit", rd_hit, 0);
    end
    repeat (5) @(negedge clk);
    chk("post_rst_ready", st_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
